dma_copy_engine: RTL and testbench

- DMA initiator that drives the card DMA command/data streams from the issuing side.
- Accepts one copy request at a time: source address, destination address, byte length.
- Splits each request into read and write bursts and buffers read data in an internal FIFO.
- Streams the buffered data back out as write data.
- Sits between the host-facing control logic and the DMA read/write channels of the memory model or shell.

---
 rtl/dma_copy_engine.sv | 188 ++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// DMA copy engine: splits one copy request into read/write bursts joined by a data FIFO.
// Optional macro DMA_COPY_4K_SPLIT_EN keeps every burst inside one 4 KiB page.
module dma_copy_engine #(
    parameter int WIDTH      = 512,
    parameter int MAX_BURST  = 4096,
    parameter int FIFO_DEPTH = 128
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [63:0]        req_src,
    input  logic [63:0]        req_dst,
    input  logic [31:0]        req_len,
    output logic               done,
    output logic               busy,
    output logic               read_cmd_valid,
    input  logic               read_cmd_ready,
    output logic [63:0]        read_cmd_address,
    output logic [31:0]        read_cmd_length,
    input  logic               read_data_valid,
    output logic               read_data_ready,
    input  logic [WIDTH-1:0]   read_data_data,
    input  logic [WIDTH/8-1:0] read_data_keep,
    input  logic               read_data_last,
    output logic               write_cmd_valid,
    input  logic               write_cmd_ready,
    output logic [63:0]        write_cmd_address,
    output logic [31:0]        write_cmd_length,
    output logic               write_data_valid,
    input  logic               write_data_ready,
    output logic [WIDTH-1:0]   write_data_data,
    output logic [WIDTH/8-1:0] write_data_keep,
    output logic               write_data_last
);
    localparam int BEAT_BYTES = WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BW         = $clog2(MAX_BURST / BEAT_BYTES) + 1;
    localparam logic [63:0] ADDR_MASK = 64'(BEAT_BYTES - 1);
    localparam logic [31:0] LEN_MASK  = 32'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_next;
    logic [63:0]        src, dst;
    logic [31:0]        rem_rd, rem_wr, len_trunc;
    logic [31:0]        rd_bound, wr_bound, rd_len, wr_len, rd_beats, wr_beats, credit;
    logic [CNT_W-1:0]   fifo_count, in_flight;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [1:0]         wq_cnt;
    logic [BW-1:0]      wq_beats0, wq_beats1, wbeat;
    logic               accept, rd_fire, wr_fire, push, pop, wr_pop;
    logic               unused_inputs;

    function automatic logic [31:0] burst_len(input logic [31:0] remaining, input logic [31:0] bound);
        logic [31:0] len;
        len = (remaining > 32'(MAX_BURST)) ? 32'(MAX_BURST) : remaining;
        if (len > bound)
            len = bound;
        return len;
    endfunction

`ifdef DMA_COPY_4K_SPLIT_EN
    assign rd_bound = 32'd4096 - 32'(src & 64'hFFF);
    assign wr_bound = 32'd4096 - 32'(dst & 64'hFFF);
`else
    assign rd_bound = 32'hFFFF_FFFF;
    assign wr_bound = 32'hFFFF_FFFF;
`endif

    assign unused_inputs = ^{read_data_keep, read_data_last};
    assign len_trunc     = req_len & ~LEN_MASK;
    assign rd_len        = burst_len(rem_rd, rd_bound);
    assign wr_len        = burst_len(rem_wr, wr_bound);
    assign rd_beats      = rd_len >> BEAT_SHIFT;
    assign wr_beats      = wr_len >> BEAT_SHIFT;
    // Beats already promised to outstanding reads count against free space, so the FIFO cannot overflow.
    assign credit        = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(in_flight);

    assign req_ready         = (state == IDLE);
    assign busy              = (state != IDLE);
    assign accept            = req_valid && req_ready;
    assign read_cmd_valid    = (state == RUN) && (rem_rd != '0) && (credit >= rd_beats);
    assign read_cmd_address  = src;
    assign read_cmd_length   = rd_len;
    assign write_cmd_valid   = (state == RUN) && (rem_wr != '0) && (wq_cnt != 2'd2);
    assign write_cmd_address = dst;
    assign write_cmd_length  = wr_len;
    assign rd_fire           = read_cmd_valid && read_cmd_ready;
    assign wr_fire           = write_cmd_valid && write_cmd_ready;

    assign read_data_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign write_data_valid = (fifo_count != '0) && (wq_cnt != 2'd0);
    assign write_data_data  = mem[rd_ptr];
    assign write_data_keep  = '1;
    assign write_data_last  = (wbeat == wq_beats0 - BW'(1));
    assign push             = read_data_valid && read_data_ready;
    assign pop              = write_data_valid && write_data_ready;
    assign wr_pop           = pop && write_data_last;

    // NOTE: combinational block assigns a default first and uses blocking '=', so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (len_trunc == '0) ? FINISH : RUN;
            RUN:     if (rem_wr == '0 && wq_cnt == 2'd0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: the data array is deliberately not reset; pointers and occupancy define what is valid.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= read_data_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done       <= 1'b0;
            src        <= '0;
            dst        <= '0;
            rem_rd     <= '0;
            rem_wr     <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wq_cnt     <= '0;
            wq_beats0  <= '0;
            wq_beats1  <= '0;
            wbeat      <= '0;
        end else begin
            done <= (state == FINISH);
            if (accept) begin
                src    <= req_src & ~ADDR_MASK;
                dst    <= req_dst & ~ADDR_MASK;
                rem_rd <= len_trunc;
                rem_wr <= len_trunc;
            end
            if (rd_fire) begin
                src    <= src + 64'(rd_len);
                rem_rd <= rem_rd - rd_len;
            end
            if (wr_fire) begin
                dst    <= dst + 64'(wr_len);
                rem_wr <= rem_wr - wr_len;
            end
            in_flight  <= in_flight + (rd_fire ? CNT_W'(rd_beats) : '0) - CNT_W'(push);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                wbeat  <= write_data_last ? '0 : wbeat + BW'(1);
            end
            // Two-entry queue of outstanding write bursts; entry 0 is the one receiving data.
            if (wr_fire && !wr_pop) begin
                if (wq_cnt == 2'd0)
                    wq_beats0 <= BW'(wr_beats);
                else
                    wq_beats1 <= BW'(wr_beats);
                wq_cnt <= wq_cnt + 2'd1;
            end else if (wr_pop && !wr_fire) begin
                wq_beats0 <= wq_beats1;
                wq_cnt    <= wq_cnt - 2'd1;
            end else if (wr_pop && wr_fire) begin
                if (wq_cnt == 2'd1) begin
                    wq_beats0 <= BW'(wr_beats);
                end else begin
                    wq_beats0 <= wq_beats1;
                    wq_beats1 <= BW'(wr_beats);
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: randomized memory-side handshakes checked against
// a byte-arithmetic burst-split model; honours DMA_COPY_4K_SPLIT_EN when defined.
`timescale 1ns/1ps
module tb_dma_copy_engine;
    localparam int W          = 512;
    localparam int BEAT_BYTES = W / 8;
    localparam int MAX_BURST  = 4096;
`ifdef DMA_COPY_4K_SPLIT_EN
    localparam bit SPLIT4K = 1'b1;
`else
    localparam bit SPLIT4K = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic             req_valid, req_ready;
    logic [63:0]      req_src, req_dst;
    logic [31:0]      req_len;
    logic             done, busy;
    logic             read_cmd_valid, read_cmd_ready;
    logic [63:0]      read_cmd_address;
    logic [31:0]      read_cmd_length;
    logic             read_data_valid, read_data_ready;
    logic [W-1:0]     read_data_data;
    logic [W/8-1:0]   read_data_keep;
    logic             read_data_last;
    logic             write_cmd_valid, write_cmd_ready;
    logic [63:0]      write_cmd_address;
    logic [31:0]      write_cmd_length;
    logic             write_data_valid, write_data_ready;
    logic [W-1:0]     write_data_data;
    logic [W/8-1:0]   write_data_keep;
    logic             write_data_last;

    always #5 clock = ~clock;

    dma_copy_engine #(.WIDTH(W), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(128)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
        .done(done), .busy(busy),
        .read_cmd_valid(read_cmd_valid), .read_cmd_ready(read_cmd_ready),
        .read_cmd_address(read_cmd_address), .read_cmd_length(read_cmd_length),
        .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
        .read_data_data(read_data_data), .read_data_keep(read_data_keep),
        .read_data_last(read_data_last),
        .write_cmd_valid(write_cmd_valid), .write_cmd_ready(write_cmd_ready),
        .write_cmd_address(write_cmd_address), .write_cmd_length(write_cmd_length),
        .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
        .write_data_data(write_data_data), .write_data_keep(write_data_keep),
        .write_data_last(write_data_last)
    );

    typedef struct { longint unsigned addr; int unsigned len; } cmd_t;
    typedef struct { logic [W-1:0] data; logic last; } beat_t;

    cmd_t            exp_rd[$], exp_wr[$];
    beat_t           exp_wd[$];
    longint unsigned rd_pend[$];

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, rd_cmd_cnt = 0, wr_cmd_cnt = 0, wd_last_cnt = 0, rd_beats_fired = 0;
    int rd_hold_until = 0;
    bit wd_rand = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Source memory contents: each beat holds 64-bit words counting up from its byte address.
    function automatic logic [W-1:0] mem_beat(input longint unsigned a);
        logic [W-1:0] d;
        for (int i = 0; i < W / 64; i++)
            d[i*64 +: 64] = 64'(a) + 64'(i);
        return d;
    endfunction

    function automatic int unsigned burst(input longint unsigned addr, input int unsigned rem);
        int unsigned b, room;
        b    = (rem < MAX_BURST) ? rem : MAX_BURST;
        room = 4096 - 32'(addr % 4096);
        if (SPLIT4K && room < b)
            b = room;
        return b;
    endfunction

    task automatic model_copy(input longint unsigned src, input longint unsigned dst, input int unsigned len);
        longint unsigned s, d, a;
        int unsigned n, rem, b, beat;
        s = src & ~64'(BEAT_BYTES - 1);
        d = dst & ~64'(BEAT_BYTES - 1);
        n = len & ~32'(BEAT_BYTES - 1);
        a = s; rem = n;
        while (rem > 0) begin
            b = burst(a, rem);
            exp_rd.push_back('{addr: a, len: b});
            a += b; rem -= b;
        end
        a = d; rem = n; beat = 0;
        while (rem > 0) begin
            b = burst(a, rem);
            exp_wr.push_back('{addr: a, len: b});
            for (int k = 0; k < int'(b) / BEAT_BYTES; k++) begin
                exp_wd.push_back('{data: mem_beat(s + 64'(BEAT_BYTES) * 64'(beat)),
                                   last: (k == int'(b) / BEAT_BYTES - 1)});
                beat++;
            end
            a += b; rem -= b;
        end
    endtask

    // Read command channel: accepts, scores, and queues the beats the memory must return.
    initial begin
        logic [63:0] held_addr;
        logic [31:0] held_len;
        bit held;
        cmd_t c;
        held = 1'b0; held_addr = '0; held_len = '0;
        read_cmd_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (held)
                    check("rd_cmd_stable", W'({read_cmd_valid, read_cmd_address, read_cmd_length}),
                          W'({1'b1, held_addr, held_len}));
                held      = read_cmd_valid && !read_cmd_ready;
                held_addr = read_cmd_address;
                held_len  = read_cmd_length;
                if (read_cmd_valid && read_cmd_ready) begin
                    rd_cmd_cnt++;
                    check("rd_cmd_expected", W'(exp_rd.size() != 0), W'(1));
                    if (exp_rd.size() != 0) begin
                        c = exp_rd.pop_front();
                        check("rd_cmd_addr", W'(read_cmd_address), W'(c.addr));
                        check("rd_cmd_len", W'(read_cmd_length), W'(c.len));
                    end
                    for (int k = 0; k < int'(read_cmd_length) / BEAT_BYTES; k++)
                        rd_pend.push_back(read_cmd_address + 64'(k * BEAT_BYTES));
                end
            end else begin
                held = 1'b0;
            end
            @(posedge clock); #1;
            read_cmd_ready = (cyc >= rd_hold_until);
        end
    end

    // Read data channel: returns queued beats with random gaps and junk keep/last.
    initial begin
        bit fired;
        read_data_valid = 1'b0; read_data_data = '0; read_data_keep = '0; read_data_last = 1'b0;
        forever begin
            @(negedge clock);
            fired = reset_n && read_data_valid && read_data_ready;
            if (fired) begin
                void'(rd_pend.pop_front());
                rd_beats_fired++;
            end
            @(posedge clock); #1;
            if (!reset_n) begin
                rd_pend.delete();
                read_data_valid = 1'b0;
            end else if (fired || !read_data_valid) begin
                if (rd_pend.size() != 0 && $urandom_range(0, 3) != 0) begin
                    read_data_valid = 1'b1;
                    read_data_data  = mem_beat(rd_pend[0]);
                    read_data_keep  = W/8'($urandom());
                    read_data_last  = 1'($urandom_range(0, 1));
                end else begin
                    read_data_valid = 1'b0;
                end
            end
        end
    end

    // Write command channel.
    initial begin
        cmd_t c;
        write_cmd_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && write_cmd_valid && write_cmd_ready) begin
                wr_cmd_cnt++;
                check("wr_cmd_expected", W'(exp_wr.size() != 0), W'(1));
                if (exp_wr.size() != 0) begin
                    c = exp_wr.pop_front();
                    check("wr_cmd_addr", W'(write_cmd_address), W'(c.addr));
                    check("wr_cmd_len", W'(write_cmd_length), W'(c.len));
                end
            end
            @(posedge clock); #1;
            write_cmd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Write data channel: every accepted beat is compared against the scoreboard.
    initial begin
        beat_t b;
        write_data_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && write_data_valid && write_data_ready) begin
                if (write_data_last) wd_last_cnt++;
                check("wd_expected", W'(exp_wd.size() != 0), W'(1));
                if (exp_wd.size() != 0) begin
                    b = exp_wd.pop_front();
                    check("wd_data", write_data_data, b.data);
                    check("wd_last", W'(write_data_last), W'(b.last));
                    check("wd_keep", W'(write_data_keep), W'({W/8{1'b1}}));
                end
            end
            @(posedge clock); #1;
            write_data_ready = wd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (done) done_cnt++;
        end
    end

    task automatic issue(input longint unsigned src, input longint unsigned dst, input int unsigned len);
        @(posedge clock); #1;
        req_valid = 1'b1; req_src = src; req_dst = dst; req_len = len;
        @(negedge clock);
        check("req_ready_idle", W'(req_ready), W'(1));
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_copy(input longint unsigned src, input longint unsigned dst, input int unsigned len);
        int d0, n;
        d0 = done_cnt;
        model_copy(src, dst, len);
        issue(src, dst, len);
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        check("done_pulses", W'(done_cnt - d0), W'(1));
        check("queues_drained", W'(exp_rd.size() + exp_wr.size() + exp_wd.size()), W'(0));
        check("idle_after", W'({busy, req_ready}), W'(2'b01));
    endtask

    initial begin
        int l0, r0, n;
        req_valid = 1'b0; req_src = '0; req_dst = '0; req_len = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", W'({req_ready, busy, done, read_cmd_valid, write_cmd_valid, write_data_valid}),
              W'(6'b100000));
        reset_n = 1'b1;

        // 8 KiB aligned copy: two 4 KiB reads and writes, 128 beats.
        l0 = wd_last_cnt; r0 = rd_cmd_cnt;
        run_copy(64'h0, 64'h10000, 8192);
        check("copy8k_rd_cmds", W'(rd_cmd_cnt - r0), W'(2));
        check("copy8k_lasts", W'(wd_last_cnt - l0), W'(2));

        // Zero-length request: no commands, done in the second cycle after acceptance.
        issue(64'h1234, 64'h5678, 32'd63);
        @(negedge clock);
        check("zl_cycle1", W'({done, busy, read_cmd_valid, write_cmd_valid}), W'(4'b0100));
        @(negedge clock);
        check("zl_cycle2", W'({done, busy, req_ready, read_cmd_valid, write_cmd_valid}), W'(5'b10100));
        @(negedge clock);
        check("zl_cycle3", W'({done, req_ready}), W'(2'b01));

        // Page-crossing source: split into two reads only when the 4 KiB rule is built in.
        r0 = rd_cmd_cnt;
        run_copy(64'hF00, 64'h2000, 512);
        check("split_rd_cmds", W'(rd_cmd_cnt - r0), W'(SPLIT4K ? 2 : 1));

        // Backpressure: reads held off for 20 cycles, random write data ready, 256 beats.
        wd_rand = 1'b1;
        rd_hold_until = cyc + 22;
        l0 = wd_last_cnt;
        run_copy(64'h40, 64'h20000, 16384);
        check("bp_lasts", W'(wd_last_cnt - l0), W'(4));
        wd_rand = 1'b0;

        // Reset while the third read beat is on the bus.
        model_copy(64'h30000, 64'h50000, 4096);
        r0 = rd_beats_fired;
        issue(64'h30000, 64'h50000, 4096);
        n = 0;
        while (!(rd_beats_fired - r0 >= 2 && read_data_valid) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("third_beat_seen", W'(n < 2000), W'(1));
        #1 reset_n = 1'b0;
        #1;
        check("abort_outputs", W'({read_cmd_valid, write_cmd_valid, write_data_valid, busy, done, req_ready}),
              W'(6'b000001));
        exp_rd.delete(); exp_wr.delete(); exp_wd.delete();
        r0 = done_cnt;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        check("abort_no_done", W'(done_cnt - r0), W'(0));
        run_copy(64'h800, 64'h9000, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
